// File: rtl/conv3x3_window_pkg.sv
// Shared types and constants for the 3x3 sliding-window block.
// Optional window sum is enabled by the CONV3X3_WINDOW_SUM_EN macro.
package conv_pkg;

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Window slots are row-major, slot 0 = oldest row / oldest column.
  localparam int SLOT_TOP_RIGHT = 2;
  localparam int SLOT_MID_RIGHT = 5;
  localparam int SLOT_CUR       = 8;
  localparam int WIN_SLOTS      = 9;

  // 9 * (2^N - 1) fits in N + 4 bits.
  localparam int SUM_EXTRA_W = 4;

  function automatic int slot_idx(input int row, input int col);
    return row * 3 + col;
  endfunction

endpackage

// File: rtl/conv3x3_window_if.sv
// Pixel-stream bundle for conv3x3_window; Win_Sum exists only with CONV3X3_WINDOW_SUM_EN.
// In_Valid=1 means the pixel on In is taken on that rising edge; there is no backpressure.
interface conv3x3_window_if #(
    parameter int Datawidth = 8
) ();
    logic                     In_Valid;
    logic [Datawidth-1:0]     In;
    logic                     Out_Valid;
    logic [9*Datawidth-1:0]   Window;
    logic                     Frame_Done;
`ifdef CONV3X3_WINDOW_SUM_EN
    logic [Datawidth+3:0]     Win_Sum;
`endif

    modport master (
        output In_Valid, In,
`ifdef CONV3X3_WINDOW_SUM_EN
        input  Win_Sum,
`endif
        input  Out_Valid, Window, Frame_Done
    );

    modport slave (
        input  In_Valid, In,
`ifdef CONV3X3_WINDOW_SUM_EN
        output Win_Sum,
`endif
        output Out_Valid, Window, Frame_Done
    );
endinterface

// File: rtl/conv3x3_window_row_delay.sv
// One-row pixel delay line: Out is the entry written Depth writes ago.
module row_delay #(
    parameter int Depth     = 224,
    parameter int Datawidth = 8
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 WE,
    input  logic [Datawidth-1:0] In,
    output logic [Datawidth-1:0] Out
);
    logic [Datawidth-1:0] r_mem [Depth];

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
        end else if (WE) begin
            r_mem[0] <= In;
            for (int i = 1; i < Depth; i++) r_mem[i] <= r_mem[i-1];
        end
    end

    assign Out = r_mem[Depth-1];
endmodule

// File: rtl/conv3x3_window.sv
// 3x3 neighbourhood extractor over a raster pixel stream (two row delay lines + window array).
// Define CONV3X3_WINDOW_SUM_EN to add the registered Win_Sum output.
module conv3x3_window
    import conv_pkg::*;
#(
    parameter int IMG_Width  = 224,
    parameter int IMG_Height = 224,
    parameter int Datawidth  = 8
) (
    input  logic                          CLK,
    input  logic                          CLR,
    input  logic                          In_Valid,
    input  logic [Datawidth-1:0]          In,
    output logic                          Out_Valid,
    output logic [9*Datawidth-1:0]        Window,
    output logic                          Frame_Done,
`ifdef CONV3X3_WINDOW_SUM_EN
    output logic [Datawidth+SUM_EXTRA_W-1:0] Win_Sum,
`endif
    output state_e                        o_dbg_state
);
    localparam int CW = $clog2(IMG_Width);
    localparam int RW = $clog2(IMG_Height);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_Width - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_Height - 1);

    logic [CW-1:0]        r_col;
    logic [RW-1:0]        r_row;
    state_e               r_state, w_state_next;
    logic                 r_out_valid, r_frame_done;
    logic [Datawidth-1:0] r_win [WIN_SLOTS];
    logic [Datawidth-1:0] w_win_next [WIN_SLOTS];
    logic [Datawidth-1:0] w_line_a, w_line_b;
    logic                 w_row_end, w_frame_end;

    assign w_row_end   = In_Valid && (r_col == COL_LAST);
    assign w_frame_end = w_row_end && (r_row == ROW_LAST);

    row_delay #(.Depth(IMG_Width), .Datawidth(Datawidth)) u_line_a (
        .CLK(CLK), .CLR(CLR), .WE(In_Valid), .In(In), .Out(w_line_a)
    );
    row_delay #(.Depth(IMG_Width), .Datawidth(Datawidth)) u_line_b (
        .CLK(CLK), .CLR(CLR), .WE(In_Valid), .In(w_line_a), .Out(w_line_b)
    );

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_col <= '0;
            r_row <= '0;
        end else if (In_Valid) begin
            if (w_frame_end) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_row_end) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) r_state <= FILL;
        else      r_state <= w_state_next;
    end

    // Rows 0 and 1 only prime the delay lines; windows exist from row 2 on.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL:    if (w_row_end && r_row == RW'(1)) w_state_next = STREAM;
            STREAM:  if (w_frame_end)                  w_state_next = FILL;
            default: w_state_next = FILL;
        endcase
    end

    always_comb begin
        for (int k = 0; k < WIN_SLOTS; k++) w_win_next[k] = r_win[k];
        if (In_Valid) begin
            for (int r = 0; r < 3; r++) begin
                w_win_next[slot_idx(r, 0)] = r_win[slot_idx(r, 1)];
                w_win_next[slot_idx(r, 1)] = r_win[slot_idx(r, 2)];
            end
            w_win_next[SLOT_TOP_RIGHT] = w_line_b;
            w_win_next[SLOT_MID_RIGHT] = w_line_a;
            w_win_next[SLOT_CUR]       = In;
        end
    end

    // Columns 0/1 would mix pixels from the previous row's tail, so they never qualify.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            for (int k = 0; k < WIN_SLOTS; k++) r_win[k] <= '0;
        end else begin
            r_out_valid  <= In_Valid && (r_state == STREAM) && (r_col >= CW'(2));
            r_frame_done <= w_frame_end;
            for (int k = 0; k < WIN_SLOTS; k++) r_win[k] <= w_win_next[k];
        end
    end

    for (genvar g = 0; g < WIN_SLOTS; g++) begin : g_pack
        assign Window[g*Datawidth +: Datawidth] = r_win[g];
    end

    assign Out_Valid   = r_out_valid;
    assign Frame_Done  = r_frame_done;
    assign o_dbg_state = r_state;

`ifdef CONV3X3_WINDOW_SUM_EN
    logic [Datawidth+SUM_EXTRA_W-1:0] w_sum, r_sum;

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < WIN_SLOTS; k++)
            w_sum = w_sum + {{SUM_EXTRA_W{1'b0}}, w_win_next[k]};
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR)          r_sum <= '0;
        else if (In_Valid) r_sum <= w_sum;
    end

    assign Win_Sum = r_sum;
`endif
endmodule

// File: tb/tb_conv3x3_window.sv
// Directed bench for conv3x3_window on a 4x4 image, pixel value = row*4+col.
// Build with CONV3X3_WINDOW_SUM_EN defined to also check Win_Sum.
module tb_conv3x3_window;
    import conv_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0]   px;
        logic            ov;
        logic            fd;
        logic [9*DW-1:0] win;
        int              sum;
    } vec_t;

    logic   CLK;
    logic   CLR;
    state_e dbg_state;
    int     n_vec;
    int     n_err;
    int     n_pulse;
    int     n_fd;
    vec_t   tbl [16];

    conv3x3_window_if #(.Datawidth(DW)) bus ();

    conv3x3_window #(.IMG_Width(W), .IMG_Height(H), .Datawidth(DW)) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .In_Valid   (bus.In_Valid),
        .In         (bus.In),
        .Out_Valid  (bus.Out_Valid),
        .Window     (bus.Window),
        .Frame_Done (bus.Frame_Done),
`ifdef CONV3X3_WINDOW_SUM_EN
        .Win_Sum    (bus.Win_Sum),
`endif
        .o_dbg_state(dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [9*DW-1:0] win9(input int s0, s1, s2, s3, s4, s5, s6, s7, s8);
        logic [DW-1:0] s [9];
        logic [9*DW-1:0] w;
        s[0] = DW'(s0); s[1] = DW'(s1); s[2] = DW'(s2);
        s[3] = DW'(s3); s[4] = DW'(s4); s[5] = DW'(s5);
        s[6] = DW'(s6); s[7] = DW'(s7); s[8] = DW'(s8);
        for (int k = 0; k < 9; k++) w[k*DW +: DW] = s[k];
        return w;
    endfunction

    task automatic check(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag, input logic chk_sum);
        @(negedge CLK);
        bus.In_Valid = 1'b1;
        bus.In       = v.px;
        @(posedge CLK);
        #1;
        check({tag, ".ov"}, 72'(bus.Out_Valid), 72'(v.ov));
        check({tag, ".fd"}, 72'(bus.Frame_Done), 72'(v.fd));
        if (bus.Out_Valid) n_pulse++;
        if (bus.Frame_Done) n_fd++;
        if (v.ov) begin
            check({tag, ".win"}, bus.Window, v.win);
`ifdef CONV3X3_WINDOW_SUM_EN
            if (chk_sum) check({tag, ".sum"}, 72'(bus.Win_Sum), 72'(v.sum));
`endif
        end
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge CLK);
        bus.In_Valid = 1'b0;
        bus.In       = 8'hA5;
        @(posedge CLK);
        #1;
        check({tag, ".idle_ov"}, 72'(bus.Out_Valid), 72'd0);
        check({tag, ".idle_fd"}, 72'(bus.Frame_Done), 72'd0);
    endtask

    task automatic run_frame(input string tag);
        for (int i = 0; i < 16; i++) begin
            apply_vec(tbl[i], $sformatf("%s[%0d]", tag, i), 1'b1);
            if (i == 7)  check({tag, ".state_stream"}, 72'(dbg_state), 72'(STREAM));
            if (i == 15) check({tag, ".state_fill"}, 72'(dbg_state), 72'(FILL));
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_pulse = 0; n_fd = 0;
        CLR = 1'b0;
        bus.In_Valid = 1'b0;
        bus.In = '0;

        for (int i = 0; i < 16; i++) begin
            tbl[i].px  = DW'(i);
            tbl[i].ov  = 1'b0;
            tbl[i].fd  = 1'b0;
            tbl[i].win = '0;
            tbl[i].sum = 0;
        end
        tbl[10].ov = 1'b1; tbl[10].win = win9(0, 1, 2, 4, 5, 6, 8, 9, 10);      tbl[10].sum = 45;
        tbl[11].ov = 1'b1; tbl[11].win = win9(1, 2, 3, 5, 6, 7, 9, 10, 11);     tbl[11].sum = 54;
        tbl[14].ov = 1'b1; tbl[14].win = win9(4, 5, 6, 8, 9, 10, 12, 13, 14);   tbl[14].sum = 81;
        tbl[15].ov = 1'b1; tbl[15].win = win9(5, 6, 7, 9, 10, 11, 13, 14, 15);  tbl[15].sum = 90;
        tbl[15].fd = 1'b1;

        repeat (3) @(posedge CLK);
        #1;
        check("reset.ov", 72'(bus.Out_Valid), 72'd0);
        check("reset.fd", 72'(bus.Frame_Done), 72'd0);
        check("reset.win", bus.Window, 72'd0);
        check("reset.state", 72'(dbg_state), 72'(FILL));
        @(negedge CLK);
        CLR = 1'b1;

        // Continuous frame
        n_pulse = 0; n_fd = 0;
        run_frame("cont");
        check("cont.pulses", 72'(n_pulse), 72'd4);
        check("cont.frame_done", 72'(n_fd), 72'd1);

        // Same frame with an idle cycle after every accept; window must hold
        n_pulse = 0; n_fd = 0;
        for (int i = 0; i < 16; i++) begin
            apply_vec(tbl[i], $sformatf("gap[%0d]", i), 1'b1);
            idle_cycle($sformatf("gap[%0d]", i));
            if (tbl[i].ov) check($sformatf("gap[%0d].hold", i), bus.Window, tbl[i].win);
        end
        check("gap.pulses", 72'(n_pulse), 72'd4);

        // Two frames back to back
        n_pulse = 0; n_fd = 0;
        run_frame("b2b0");
        run_frame("b2b1");
        check("b2b.pulses", 72'(n_pulse), 72'd8);
        check("b2b.frame_done", 72'(n_fd), 72'd2);

        // Reset after pixel 9 (row 2, already streaming), then a full frame
        for (int i = 0; i < 10; i++) apply_vec(tbl[i], $sformatf("pre[%0d]", i), 1'b1);
        @(negedge CLK);
        bus.In_Valid = 1'b0;
        #2 CLR = 1'b0;
        #1;
        check("midrst.ov", 72'(bus.Out_Valid), 72'd0);
        check("midrst.win", bus.Window, 72'd0);
        check("midrst.state", 72'(dbg_state), 72'(FILL));
        @(negedge CLK);
        CLR = 1'b1;
        n_pulse = 0; n_fd = 0;
        run_frame("post");
        check("post.pulses", 72'(n_pulse), 72'd4);

`ifdef CONV3X3_WINDOW_SUM_EN
        // Saturated pixels exercise the full sum width
        begin
            vec_t v;
            for (int i = 0; i < 16; i++) begin
                v = tbl[i];
                v.px = 8'hFF;
                v.win = {9{8'hFF}};
                v.sum = 2295;
                apply_vec(v, $sformatf("max[%0d]", i), 1'b1);
            end
        end
`endif

        @(negedge CLK);
        bus.In_Valid = 1'b0;
        repeat (2) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/conv3x3_window.md
CONV3X3_WINDOW -- requirements
Module: conv3x3_window

Interface
REQ-001 SHALL have parameter IMG_Width, default 224, pixels per row (min 3).
REQ-002 SHALL have parameter IMG_Height, default 224, rows per frame (min 3).
REQ-003 SHALL have parameter Datawidth, default 8, bits per pixel.
REQ-004 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port CLR  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port In_Valid  input  1  pixel on In accepted this edge.
REQ-007 SHALL have port In  input  Datawidth  raster-order pixel stream, row 0 col 0 first.
REQ-008 SHALL have port Out_Valid  output  1  Window holds a complete 3x3 neighbourhood.
REQ-009 SHALL have port Window  output  9*Datawidth  slot k at bits [k*Datawidth +: Datawidth]; slot 0 = (r-2,c-2), row-major, slot 8 = (r,c).
REQ-010 SHALL have port Frame_Done  output  1  one-cycle pulse after last pixel of frame.

Function
REQ-011 SHALL keep column counter col (0..IMG_Width-1) and row counter row (0..IMG_Height-1), advanced only on edges with In_Valid=1.
REQ-012 SHALL wrap col to 0 after IMG_Width-1 and increment row; after (IMG_Height-1, IMG_Width-1), both return to 0.
REQ-013 SHALL keep two row delay lines of IMG_Width entries; on an accepted pixel, line A takes In and line B takes line A's oldest entry.
REQ-014 SHALL shift the 3x3 register array one column on each accepted pixel: new right column = {line B out, line A out, In}.
REQ-015 SHALL hold counters, delay lines, window array and Window output unchanged while In_Valid=0.
REQ-016 SHALL use FSM states FILL (row<2) and STREAM (row>=2); FILL->STREAM on accepting last pixel of row 1; STREAM->FILL on accepting last pixel of frame.
REQ-017 SHALL assert Out_Valid for exactly one cycle, the cycle after accepting pixel (r,c) with state STREAM and c>=2; else Out_Valid=0.
REQ-018 SHALL present on Window, in that Out_Valid cycle, pixels (r-2..r, c-2..c); latency from accepting edge to Out_Valid is 1 cycle.
REQ-019 SHALL never assert Out_Valid for windows straddling a row boundary (c=0 or c=1), including c=0/1 of the first STREAM row.
REQ-020 SHALL pulse Frame_Done for one cycle after the edge accepting (IMG_Height-1, IMG_Width-1), coincident with that pixel's Out_Valid.
REQ-021 SHALL accept back-to-back frames with no idle cycle; first pixel of next frame is row 0 col 0.
REQ-022 SHALL perform no arithmetic on pixel data except under REQ-026.

Reset
REQ-023 SHALL, on CLR=0, asynchronously clear counters to 0, FSM to FILL, Out_Valid and Frame_Done to 0, Window and delay-line contents to 0.
REQ-024 SHALL, after reset mid-frame, treat the next accepted pixel as row 0 col 0; no stale window shall reach Out_Valid.

Configuration
REQ-025 SHALL compile optional port Win_Sum (output, Datawidth+4 bits) only when macro CONV3X3_WINDOW_SUM_EN is defined.
REQ-026 SHALL, with CONV3X3_WINDOW_SUM_EN, register the unsigned sum of the 9 window pixels, valid with Out_Valid, reset to 0; without it, no sum logic or port exists and REQ-001..024 are unchanged.

Structure
REQ-027 SHALL place FSM state encoding (FILL, STREAM), window slot index constants and sum-width constant in shared package conv_pkg.
REQ-028 SHALL implement each delay line as one instance of sub-module row_delay (parameters Depth, Datawidth; ports CLK, CLR, WE, In, Out).

Verification (IMG_Width=4, IMG_Height=4, Datawidth=8, pixel = row*4+col)
REQ-029 SHALL cover: continuous 16-pixel frame -> exactly 4 Out_Valid pulses; first Window = {0,1,2,4,5,6,8,9,10}, last = {5,6,7,9,10,11,13,14,15}.
REQ-030 SHALL cover: same frame with In_Valid=0 every other cycle -> identical 4 windows, Out_Valid never on an idle-following cycle without an accept.
REQ-031 SHALL cover: two frames back-to-back -> Frame_Done pulses after pixel 15 of each; 8 windows total, second frame windows identical to first.
REQ-032 SHALL cover: CLR low after pixel 9 of a frame, then full frame -> no Out_Valid before the new frame's pixel (2,2); windows as REQ-029.
REQ-033 SHALL cover: with CONV3X3_WINDOW_SUM_EN -> Win_Sum=45 on first window, 90 on last; all pixels 255 -> Win_Sum=2295.
